// File: rtl/set_key_scheduler_pkg.sv
// Shared types for the set-key scheduler: FSM state encodings, key ownership,
// target select constants and the step-routing helper.
package set_key_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FIRST    = 3'd1,
        ST_HOLD     = 3'd2,
        ST_REPEAT   = 3'd3,
        ST_WAIT_REL = 3'd4
    } state_e;

    typedef enum logic {
        OWNER_MM = 1'b0,
        OWNER_HH = 1'b1
    } owner_e;

    localparam logic TARGET_CLOCK = 1'b1;
    localparam logic TARGET_ALARM = 1'b0;

    // Returns {alarm24, alarm60, clock24, clock60} for one manual step.
    function automatic logic [3:0] route_step(input logic step, input owner_e owner,
                                              input logic target);
        logic [3:0] r;
        r = 4'b0000;
        if (step) begin
            if (owner == OWNER_MM && target == TARGET_CLOCK) r[0] = 1'b1;
            if (owner == OWNER_HH && target == TARGET_CLOCK) r[1] = 1'b1;
            if (owner == OWNER_MM && target == TARGET_ALARM) r[2] = 1'b1;
            if (owner == OWNER_HH && target == TARGET_ALARM) r[3] = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/set_key_scheduler_autorep_timer.sv
// Loadable down-counter for hold/repeat delays; stops at zero and flags it.
module set_key_scheduler_autorep_timer #(
    parameter int CNT_W = 5
) (
    input  logic             ck,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count_reg;

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (en && count_reg != '0) begin
            count_reg <= count_reg - CNT_W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/set_key_scheduler.sv
// Turns mm/hh set-key presses into single steps plus auto-repeat pulses for the
// clock/alarm minute and hour counters, merging the timebase minute tick.
module set_key_scheduler
    import set_key_scheduler_pkg::*;
#(
    parameter int HOLD_CYCLES   = 20,
    parameter int REPEAT_CYCLES = 5,
    parameter int CNT_W         = 5
) (
    input  logic ck,
    input  logic reset,
    input  logic mm,
    input  logic hh,
    input  logic clock_alarm,
    input  logic min,
    output logic up_clock60,
    output logic up_clock24,
    output logic up_alarm60,
    output logic up_alarm24,
    output logic busy
);

    state_e     state_reg, state_next;
    owner_e     owner_reg, owner_next;
    logic       target_reg, target_next;
    logic       mm_prev_reg, hh_prev_reg;
    logic       first_idle_reg;
    logic       pending_reg, pending_next;
    logic       step;
    logic       tmr_load, tmr_en, tmr_zero;
    logic [CNT_W-1:0] tmr_load_value;
    logic       owner_held;
    logic       mm_rise, hh_rise;
    logic [3:0] route;
    logic [1:0] c60_sum;

    assign mm_rise    = mm & ~mm_prev_reg;
    assign hh_rise    = hh & ~hh_prev_reg;
    assign owner_held = (owner_reg == OWNER_MM) ? mm : hh;

    set_key_scheduler_autorep_timer #(.CNT_W(CNT_W)) u_timer (
        .ck         (ck),
        .reset      (reset),
        .load       (tmr_load),
        .load_value (tmr_load_value),
        .en         (tmr_en),
        .zero       (tmr_zero)
    );

    always_ff @(posedge ck or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= OWNER_MM;
            target_reg     <= TARGET_ALARM;
            mm_prev_reg    <= 1'b0;
            hh_prev_reg    <= 1'b0;
            first_idle_reg <= 1'b1;
            pending_reg    <= 1'b0;
            up_clock60     <= 1'b0;
            up_clock24     <= 1'b0;
            up_alarm60     <= 1'b0;
            up_alarm24     <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            target_reg     <= target_next;
            mm_prev_reg    <= mm;
            hh_prev_reg    <= hh;
            first_idle_reg <= 1'b0;
            pending_reg    <= pending_next;
            up_clock60     <= (c60_sum != 2'd0);
            up_clock24     <= route[1];
            up_alarm60     <= route[2];
            up_alarm24     <= route[3];
            busy           <= (state_next != ST_IDLE);
        end
    end

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        target_next    = target_reg;
        step           = 1'b0;
        tmr_load       = 1'b0;
        tmr_load_value = '0;
        tmr_en         = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // A key already down as reset lifts must be released before it counts.
                if (first_idle_reg && (mm || hh)) begin
                    state_next = ST_WAIT_REL;
                end else if (mm_rise) begin
                    owner_next  = OWNER_MM;
                    target_next = clock_alarm;
                    state_next  = ST_FIRST;
                end else if (hh_rise) begin
                    owner_next  = OWNER_HH;
                    target_next = clock_alarm;
                    state_next  = ST_FIRST;
                end
            end
            ST_FIRST: begin
                step           = 1'b1;
                tmr_load       = 1'b1;
                tmr_load_value = CNT_W'(HOLD_CYCLES - 1);
                state_next     = owner_held ? ST_HOLD : ST_IDLE;
            end
            ST_HOLD, ST_REPEAT: begin
                if (!owner_held) begin
                    state_next = ST_IDLE;
                end else if (tmr_zero) begin
                    step           = 1'b1;
                    tmr_load       = 1'b1;
                    tmr_load_value = CNT_W'(REPEAT_CYCLES - 1);
                    state_next     = ST_REPEAT;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_WAIT_REL: begin
                if (!mm && !hh) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // A minute tick colliding with a manual step is deferred one cycle, not dropped.
    always_comb begin
        route        = route_step(step, owner_reg, target_reg);
        c60_sum      = {1'b0, min} + {1'b0, route[0]} + {1'b0, pending_reg};
        pending_next = (c60_sum >= 2'd2);
    end

endmodule

// File: tb/tb_set_key_scheduler.sv
// Self-checking bench for set_key_scheduler: expected pulse cycles are queued
// per output when stimulus is driven and consumed by a negedge monitor.
module tb_set_key_scheduler;

    logic ck = 1'b0;
    logic reset = 1'b1;
    logic mm = 1'b0;
    logic hh = 1'b0;
    logic clock_alarm = 1'b0;
    logic min = 1'b0;
    logic up_clock60, up_clock24, up_alarm60, up_alarm24, busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    // index 0=clock60, 1=clock24, 2=alarm60, 3=alarm24
    int exp_q [4][$];

    set_key_scheduler #(
        .HOLD_CYCLES(20), .REPEAT_CYCLES(5), .CNT_W(5)
    ) dut (
        .ck(ck), .reset(reset), .mm(mm), .hh(hh), .clock_alarm(clock_alarm),
        .min(min), .up_clock60(up_clock60), .up_clock24(up_clock24),
        .up_alarm60(up_alarm60), .up_alarm24(up_alarm24), .busy(busy)
    );

    always #5 ck = ~ck;

    always @(posedge ck) cyc <= cyc + 1;

    always @(negedge ck) begin
        logic [3:0] obs;
        logic exp_bit;
        obs = {up_alarm24, up_alarm60, up_clock24, up_clock60};
        for (int k = 0; k < 4; k++) begin
            exp_bit = 1'b0;
            if (exp_q[k].size() > 0 && exp_q[k][0] == cyc) begin
                exp_bit = 1'b1;
                void'(exp_q[k].pop_front());
            end
            if (obs[k] !== 1'b0 || exp_bit) begin
                checks++;
                if (obs[k] !== exp_bit) begin
                    errors++;
                    $display("FAIL pulse out%0d cyc=%0d got=%0b expected=%0b", k, cyc, obs[k], exp_bit);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge ck);
    endtask

    task automatic check_drained(input string tag);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (exp_q[k].size() !== 0) begin
                errors++;
                $display("FAIL %s out%0d missing pulses got_left=%0d expected=0", tag, k, exp_q[k].size());
                exp_q[k].delete();
            end
        end
    endtask

    task automatic test_reset();
        #1 reset = 1'b0;
        #6;
        checks++;
        if ({up_alarm24, up_alarm60, up_clock24, up_clock60} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b expected=0000", {up_alarm24, up_alarm60, up_clock24, up_clock60});
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b expected=0", busy);
        end
        @(negedge ck);
        reset = 1'b1;
        tick(3);
    endtask

    task automatic test_short_press();
        int press;
        clock_alarm = 1'b1;
        mm = 1'b1;
        press = cyc + 1;
        exp_q[0].push_back(press + 1);
        tick(1);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL short_busy_rise got=%b expected=1", busy);
        end
        tick(2);
        mm = 1'b0;
        tick(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL short_busy_fall got=%b expected=0", busy);
        end
        tick(10);
        check_drained("short_press");
    endtask

    task automatic test_long_hold();
        int press;
        int offs[7] = '{1, 21, 26, 31, 36, 41, 46};
        clock_alarm = 1'b0;
        mm = 1'b1;
        press = cyc + 1;
        for (int i = 0; i < 7; i++) exp_q[2].push_back(press + offs[i]);
        tick(50);
        mm = 1'b0;
        tick(10);
        check_drained("long_hold");
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL long_busy got=%b expected=0", busy);
        end
    endtask

    task automatic test_collision();
        int press;
        clock_alarm = 1'b1;
        hh = 1'b1;
        press = cyc + 1;
        exp_q[1].push_back(press + 1);
        tick(5);
        mm = 1'b1;
        tick(5);
        hh = 1'b0;
        tick(5);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL collision_nonowner_held got=%b expected=0", busy);
        end
        mm = 1'b0;
        tick(2);
        mm = 1'b1;
        press = cyc + 1;
        exp_q[0].push_back(press + 1);
        tick(3);
        mm = 1'b0;
        tick(5);
        check_drained("collision_repress");
        // simultaneous rise: mm owns, hh stays ignored while held
        clock_alarm = 1'b0;
        mm = 1'b1;
        hh = 1'b1;
        press = cyc + 1;
        exp_q[2].push_back(press + 1);
        tick(3);
        mm = 1'b0;
        tick(8);
        hh = 1'b0;
        tick(3);
        check_drained("collision_same_cycle");
    endtask

    task automatic test_merge();
        int press;
        min = 1'b1;
        exp_q[0].push_back(cyc + 1);
        tick(1);
        min = 1'b0;
        tick(4);
        check_drained("merge_min_alone");
        clock_alarm = 1'b1;
        mm = 1'b1;
        press = cyc + 1;
        exp_q[0].push_back(press + 1);
        exp_q[0].push_back(press + 2);
        tick(1);
        min = 1'b1;
        tick(1);
        min = 1'b0;
        tick(1);
        mm = 1'b0;
        tick(5);
        check_drained("merge_collision");
    endtask

    task automatic test_target_latch();
        int press;
        clock_alarm = 1'b1;
        mm = 1'b1;
        press = cyc + 1;
        exp_q[0].push_back(press + 1);
        exp_q[0].push_back(press + 21);
        exp_q[0].push_back(press + 26);
        tick(10);
        clock_alarm = 1'b0;
        tick(20);
        mm = 1'b0;
        tick(8);
        check_drained("target_latch");
        // reset mid-repeat with the key kept down
        clock_alarm = 1'b1;
        mm = 1'b1;
        press = cyc + 1;
        exp_q[0].push_back(press + 1);
        exp_q[0].push_back(press + 21);
        exp_q[0].push_back(press + 26);
        tick(27);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({up_alarm24, up_alarm60, up_clock24, up_clock60, busy} !== 5'b00000) begin
            errors++;
            $display("FAIL midreset_outputs got=%b expected=00000", {up_alarm24, up_alarm60, up_clock24, up_clock60, busy});
        end
        tick(2);
        reset = 1'b1;
        tick(30);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_wait_release got=%b expected=1", busy);
        end
        mm = 1'b0;
        tick(2);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_released got=%b expected=0", busy);
        end
        mm = 1'b1;
        press = cyc + 1;
        exp_q[0].push_back(press + 1);
        tick(3);
        mm = 1'b0;
        tick(5);
        check_drained("after_reset_repress");
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_long_hold();
        test_collision();
        test_merge();
        test_target_latch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
